fmc_reg_slave: RTL and testbench
================================

FMC_REG_SLAVE -- requirements
Module: fmc_reg_slave

Interface
REQ-001 Parameter ADDR_W, default 12: FMC address width.
REQ-002 Parameter DATA_W, default 8: FMC data width.
REQ-003 Parameter RD_TIMEOUT, default 16: clk cycles to wait for rd_valid before substituting RD_DEFAULT.
REQ-004 Parameter RD_DEFAULT, default 8'hEE: read data returned on timeout.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: system clock, single domain, 100 MHz nominal.
- rst_n, in, 1: reset, synchronous, active-low.
- fmc_ncs, in, 1: ARM chip select, asynchronous, active-low.
- fmc_nwe, in, 1: ARM write enable, asynchronous, active-low.
- fmc_noe, in, 1: ARM output enable, asynchronous, active-low.
- fmc_addr, in, ADDR_W: ARM address.
- fmc_data_i, in, DATA_W: bus data from ARM, via the top-level tristate.
- fmc_data_o, out, DATA_W: bus data to ARM.
- fmc_data_oe, out, 1: tristate enable for fmc_data_o, high = FPGA drives.
- wr_en, out, 1: one-cycle write strobe to the register file.
- wr_addr, out, ADDR_W: write address, valid with wr_en.
- wr_data, out, DATA_W: write data, valid with wr_en.
- rd_req, out, 1: one-cycle read request.
- rd_addr, out, ADDR_W: read address, held from rd_req until the cycle completes.
- rd_data, in, DATA_W: register-file read data.
- rd_valid, in, 1: rd_data valid, may arrive 0 or more cycles after rd_req.

Function
REQ-006 fmc_ncs, fmc_nwe and fmc_noe SHALL each pass through a 2-FF synchronizer; fmc_addr and fmc_data_i SHALL be sampled in the same cycles as the synchronized strobes.
REQ-007 FSM states SHALL be IDLE, WR_ACT, RD_WAIT, RD_HOLD.
REQ-008 IDLE->WR_ACT SHALL occur when synchronized ncs=0 and nwe=0; IDLE->RD_WAIT SHALL occur when ncs=0, noe=0 and nwe=1.
REQ-009 In WR_ACT, fmc_data_i and fmc_addr SHALL be registered every cycle while nwe=0.
REQ-010 On synchronized nwe rising, or ncs rising, in WR_ACT: wr_en SHALL pulse exactly one cycle carrying the last registered addr/data, and the FSM SHALL return to IDLE.
REQ-011 wr_en SHALL assert no later than 4 clk cycles after the raw nWE rising edge.
REQ-012 On entry to RD_WAIT: rd_req SHALL pulse one cycle; rd_addr SHALL latch the synchronized address.
REQ-013 In RD_WAIT, rd_valid SHALL load fmc_data_o and move the FSM to RD_HOLD; if rd_valid arrives in the same cycle as rd_req, it SHALL be accepted.
REQ-014 If RD_TIMEOUT cycles elapse in RD_WAIT without rd_valid, fmc_data_o SHALL load RD_DEFAULT and the FSM SHALL move to RD_HOLD.
REQ-015 fmc_data_oe SHALL be high only in RD_HOLD; fmc_data_o SHALL stay stable throughout RD_HOLD.
REQ-016 RD_HOLD->IDLE SHALL occur on synchronized noe=1 or ncs=1, and fmc_data_oe SHALL drop in that same cycle.
REQ-017 In RD_WAIT, ncs or noe rising SHALL abort to IDLE with no data driven; a late rd_valid SHALL be ignored.
REQ-018 nwe/noe activity while ncs=1 SHALL produce no strobe.
REQ-019 Simultaneous nwe=0 and noe=0 in IDLE SHALL be treated as a write.
REQ-020 Back-to-back cycles SHALL require ncs, nwe and noe to return high, i.e. pass through IDLE; no strobe SHALL repeat within one bus cycle.

Reset
REQ-021 When rst_n=0 at a clk edge: FSM SHALL go to IDLE; wr_en, rd_req and fmc_data_oe SHALL be 0; fmc_data_o, wr_addr, wr_data and rd_addr SHALL be 0; synchronizers SHALL be preset to 1, the inactive state.
REQ-022 Reset mid-cycle SHALL drop fmc_data_oe immediately, and no strobe SHALL be emitted for the interrupted cycle.

Configuration
REQ-023 Macro FMC_READBACK_EN: when defined, the read path (RD_WAIT/RD_HOLD, timeout counter) SHALL be compiled in.
REQ-024 When FMC_READBACK_EN is undefined: rd_req and fmc_data_oe SHALL be tied 0; fmc_data_o SHALL be tied 0; noe SHALL be ignored; the write path SHALL be unchanged.

Structure
REQ-025 The FSM state enum, ADDR_W/DATA_W defaults and RD_DEFAULT SHALL live in shared package fmc_pkg.
REQ-026 One sub-module, fmc_sync2 (parameterised 2-FF synchronizer with reset value), SHALL be used for the three strobes.

Verification
REQ-027 Write 0x02D<-0x0F (nCS low, 62.5 ns setup, nWE low 40 ns) -> exactly one wr_en, wr_addr=0x02D, wr_data=0x0F, within 4 clk of nWE rise.
REQ-028 Six back-to-back writes 0x003..0x008 with bytes of 48'd9007199254740 -> six wr_en pulses, in order, with matching addr/data.
REQ-029 Read 0x204, rd_valid 2 cycles after rd_req with rd_data=0x5A -> fmc_data_oe high, fmc_data_o=0x5A until nOE rises; exactly one rd_req with rd_addr=0x204.
REQ-030 Read with rd_valid never asserted -> after 16 cycles, fmc_data_o=0xEE driven until nOE rises.
REQ-031 nWE pulse while nCS=1, and nOE release during RD_WAIT -> no wr_en; abort to IDLE with oe never high.
REQ-032 rst_n=0 during RD_HOLD -> fmc_data_oe=0 on the next edge; then a normal write is accepted. Repeat the write with FMC_READBACK_EN undefined -> identical wr_en and fmc_data_oe always 0.

Source files
------------

// File: rtl/fmc_pkg.sv
// ---------------------------------------------------------------------------
// fmc_pkg : shared FMC slave types and defaults.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package fmc_pkg;

  localparam int         c_ADDR_W     = 12;
  localparam int         c_DATA_W     = 8;
  localparam logic [7:0] c_RD_DEFAULT = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_ACT  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_HOLD = 2'd3
  } fmc_state_t;

endpackage

`default_nettype wire

// File: rtl/fmc_sync2.sv
// ---------------------------------------------------------------------------
// fmc_sync2 : parameterised 2-FF synchronizer with programmable reset value.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module fmc_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/fmc_reg_slave.sv
// ---------------------------------------------------------------------------
// fmc_reg_slave : ARM FMC async bus to register-file write/read strobes.
//   Read path compiled in only with FMC_READBACK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module fmc_reg_slave
  import fmc_pkg::*;
#(
  parameter int                ADDR_W     = c_ADDR_W,
  parameter int                DATA_W     = c_DATA_W,
  parameter int                RD_TIMEOUT = 16,
  parameter logic [DATA_W-1:0] RD_DEFAULT = DATA_W'(c_RD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fmc_ncs,
  input  logic              fmc_nwe,
  input  logic              fmc_noe,
  input  logic [ADDR_W-1:0] fmc_addr,
  input  logic [DATA_W-1:0] fmc_data_i,
  output logic [DATA_W-1:0] fmc_data_o,
  output logic              fmc_data_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid
);

  logic [2:0]        w_strb_s;
  logic              w_ncs_s, w_nwe_s, w_noe_s;
  fmc_state_t        r_state, w_state_nxt;
  logic              r_armed;
  logic [ADDR_W-1:0] r_addr_d1, r_addr_d2, r_wr_addr;
  logic [DATA_W-1:0] r_data_d1, r_data_d2, r_wr_data;
  logic              r_wr_en;
  logic              w_idle_bus, w_wr_start, w_wr_capture, w_wr_done;

  fmc_sync2 #(.WIDTH(3), .RST_VAL(3'b111)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async ({fmc_ncs, fmc_nwe, fmc_noe}),
    .o_sync  (w_strb_s)
  );
  assign {w_ncs_s, w_nwe_s, w_noe_s} = w_strb_s;

`ifdef FMC_READBACK_EN
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_data_o;
  logic              w_timeout, w_rd_start, w_rd_req, w_data_oe;

  assign w_timeout  = (r_cnt == CNT_W'(RD_TIMEOUT - 1));
  assign w_idle_bus = w_ncs_s & w_nwe_s & w_noe_s;
`else
  assign w_idle_bus = w_ncs_s & w_nwe_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A new bus cycle may only start once every strobe has been seen inactive.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_ncs_s) begin
          if (!w_nwe_s) w_state_nxt = ST_WR_ACT;
`ifdef FMC_READBACK_EN
          else if (!w_noe_s) w_state_nxt = ST_RD_WAIT;
`endif
        end
      end
      ST_WR_ACT: if (w_ncs_s || w_nwe_s) w_state_nxt = ST_IDLE;
`ifdef FMC_READBACK_EN
      ST_RD_WAIT: begin
        if (w_ncs_s || w_noe_s)      w_state_nxt = ST_IDLE;
        else if (rd_valid || w_timeout) w_state_nxt = ST_RD_HOLD;
      end
      ST_RD_HOLD: if (w_ncs_s || w_noe_s) w_state_nxt = ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wr_start   = (r_state == ST_IDLE) && (w_state_nxt == ST_WR_ACT);
    w_wr_capture = w_wr_start || ((r_state == ST_WR_ACT) && (w_state_nxt == ST_WR_ACT));
    w_wr_done    = (r_state == ST_WR_ACT) && (w_state_nxt == ST_IDLE);
`ifdef FMC_READBACK_EN
    w_rd_start   = (r_state == ST_IDLE) && (w_state_nxt == ST_RD_WAIT);
    w_rd_req     = (r_state == ST_RD_WAIT) && (r_cnt == '0);
    w_data_oe    = (r_state == ST_RD_HOLD);
`endif
  end

  // Address/data are delayed two cycles so they line up with the synchronized strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_d1 <= '0;
      r_addr_d2 <= '0;
      r_data_d1 <= '0;
      r_data_d2 <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_addr_d1 <= fmc_addr;
      r_addr_d2 <= r_addr_d1;
      r_data_d1 <= fmc_data_i;
      r_data_d2 <= r_data_d1;
      r_wr_en   <= w_wr_done;
      if (w_wr_capture) begin
        r_wr_addr <= r_addr_d2;
        r_wr_data <= r_data_d2;
      end
      if (w_idle_bus)
        r_armed <= 1'b1;
      else if ((r_state == ST_IDLE) && (w_state_nxt != ST_IDLE))
        r_armed <= 1'b0;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

`ifdef FMC_READBACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_data_o  <= '0;
    end else begin
      r_cnt <= (r_state == ST_RD_WAIT) ? r_cnt + 1'b1 : '0;
      if (w_rd_start)
        r_rd_addr <= r_addr_d2;
      if ((r_state == ST_RD_WAIT) && (w_state_nxt == ST_RD_HOLD))
        r_data_o <= rd_valid ? rd_data : RD_DEFAULT;
    end
  end

  assign rd_req      = w_rd_req;
  assign rd_addr     = r_rd_addr;
  assign fmc_data_o  = r_data_o;
  assign fmc_data_oe = w_data_oe;
`else
  logic w_unused_rd;
  assign w_unused_rd = (^{w_noe_s, rd_data, rd_valid, RD_DEFAULT}) ^ RD_TIMEOUT[0];

  assign rd_req      = 1'b0;
  assign rd_addr     = '0;
  assign fmc_data_o  = '0;
  assign fmc_data_oe = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fmc_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_fmc_reg_slave : directed self-checking bench for fmc_reg_slave.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fmc_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fmc_ncs = 1'b1;
  logic        fmc_nwe = 1'b1;
  logic        fmc_noe = 1'b1;
  logic [11:0] fmc_addr = '0;
  logic [7:0]  fmc_data_i = '0;
  logic [7:0]  fmc_data_o;
  logic        fmc_data_oe;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        rd_valid = 1'b0;

  fmc_reg_slave u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fmc_ncs     (fmc_ncs),
    .fmc_nwe     (fmc_nwe),
    .fmc_noe     (fmc_noe),
    .fmc_addr    (fmc_addr),
    .fmc_data_i  (fmc_data_i),
    .fmc_data_o  (fmc_data_o),
    .fmc_data_oe (fmc_data_oe),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdq_cnt = 0;
  bit          oe_seen = 1'b0;
  logic [11:0] last_rd_addr = '0;
  logic [11:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];

  always @(negedge clk) begin
    if (wr_en) begin
      wr_addr_log.push_back(wr_addr);
      wr_data_log.push_back(wr_data);
    end
    if (rd_req) begin
      rdq_cnt++;
      last_rd_addr = rd_addr;
    end
    if (fmc_data_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  task automatic fmc_write(input logic [11:0] a, input logic [7:0] d, input bit with_noe);
    bit seen;
    fmc_addr = a;
    fmc_data_i = d;
    fmc_ncs = 1'b0;
    #62.5;
    fmc_nwe = 1'b0;
    if (with_noe) fmc_noe = 1'b0;
    #40;
    fmc_nwe = 1'b1;
    fmc_noe = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 4 && !seen; i++) begin
      @(posedge clk); #1;
      if (wr_en) seen = 1'b1;
    end
    check("wr_en_within_4clk", 32'(seen), 32'd1);
    #10;
    fmc_ncs = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic start_read(input logic [11:0] a, output bit ok);
    fmc_addr = a;
    fmc_ncs = 1'b0;
    #62.5;
    fmc_noe = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (rd_req) ok = 1'b1;
    end
  endtask

  task automatic end_read(input string tag);
    bit dropped;
    fmc_noe = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 5 && !dropped; i++) begin
      @(negedge clk);
      if (!fmc_data_oe) dropped = 1'b1;
    end
    check(tag, 32'(dropped), 32'd1);
    fmc_ncs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] pat;
    logic [7:0]  exp_bytes [6];
    bit          ok;
    int          rq0;
    int          k;
    int          bad;

    pat = 48'd9007199254740;
    exp_bytes = '{8'hD4, 8'h78, 8'hE9, 8'h26, 8'h31, 8'h08};

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",   32'(wr_en),       32'd0);
    check("rst_rd_req",  32'(rd_req),      32'd0);
    check("rst_oe",      32'(fmc_data_oe), 32'd0);
    check("rst_data_o",  32'(fmc_data_o),  32'd0);
    check("rst_wr_addr", 32'(wr_addr),     32'd0);
    check("rst_wr_data", 32'(wr_data),     32'd0);
    check("rst_rd_addr", 32'(rd_addr),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    clear_log();
    fmc_write(12'h02D, 8'h0F, 1'b0);
    check("w1_pulses", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() == 1) begin
      check("w1_addr", 32'(wr_addr_log[0]), 32'h02D);
      check("w1_data", 32'(wr_data_log[0]), 32'h0F);
    end

    clear_log();
    for (int i = 0; i < 6; i++) fmc_write(12'(3 + i), pat[8*i +: 8], 1'b0);
    check("b2b_pulses", 32'(wr_addr_log.size()), 32'd6);
    if (wr_addr_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("b2b_addr", 32'(wr_addr_log[i]), 32'(3 + i));
        check("b2b_data", 32'(wr_data_log[i]), 32'(exp_bytes[i]));
      end
    end

    clear_log();
    fmc_nwe = 1'b0;
    #40;
    fmc_nwe = 1'b1;
    repeat (6) @(negedge clk);
    check("nwe_ncs_high_pulses", 32'(wr_addr_log.size()), 32'd0);

    clear_log();
    rq0 = rdq_cnt;
    fmc_write(12'h7A5, 8'hC3, 1'b1);
    check("wr_rd_pulses", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() == 1) begin
      check("wr_rd_addr", 32'(wr_addr_log[0]), 32'h7A5);
      check("wr_rd_data", 32'(wr_data_log[0]), 32'hC3);
    end
    check("wr_rd_no_rdreq", 32'(rdq_cnt - rq0), 32'd0);

`ifdef FMC_READBACK_EN
    rq0 = rdq_cnt;
    start_read(12'h204, ok);
    check("rd_req_seen", 32'(ok), 32'd1);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_data = 8'h5A;
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data = 8'h00;
    check("rd_oe", 32'(fmc_data_oe), 32'd1);
    check("rd_data_o", 32'(fmc_data_o), 32'h5A);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!fmc_data_oe || fmc_data_o != 8'h5A) bad++;
    end
    check("rd_hold_stable", 32'(bad), 32'd0);
    end_read("rd_oe_drop");
    check("rd_req_count", 32'(rdq_cnt - rq0), 32'd1);
    check("rd_addr", 32'(last_rd_addr), 32'h204);

    start_read(12'h155, ok);
    check("to_rd_req_seen", 32'(ok), 32'd1);
    k = 0;
    while (k < 30 && !fmc_data_oe) begin
      @(negedge clk);
      k++;
    end
    check("to_cycles", 32'(k), 32'd16);
    check("to_data_o", 32'(fmc_data_o), 32'hEE);
    end_read("to_oe_drop");

    clear_log();
    oe_seen = 1'b0;
    start_read(12'h0AA, ok);
    check("ab_rd_req_seen", 32'(ok), 32'd1);
    @(negedge clk);
    fmc_noe = 1'b1;
    repeat (4) @(negedge clk);
    rd_valid = 1'b1;
    rd_data = 8'h11;
    @(negedge clk);
    rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    fmc_ncs = 1'b1;
    repeat (4) @(negedge clk);
    check("ab_oe_never", 32'(oe_seen), 32'd0);
    check("ab_no_wr", 32'(wr_addr_log.size()), 32'd0);

    rd_valid = 1'b1;
    rd_data = 8'h3C;
    start_read(12'h321, ok);
    check("rst_rd_req_seen", 32'(ok), 32'd1);
    @(negedge clk);
    rd_valid = 1'b0;
    check("same_cycle_oe", 32'(fmc_data_oe), 32'd1);
    check("same_cycle_data", 32'(fmc_data_o), 32'h3C);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_hold_oe", 32'(fmc_data_oe), 32'd0);
`else
    oe_seen = 1'b0;
    rq0 = rdq_cnt;
    fmc_addr = 12'h204;
    fmc_ncs = 1'b0;
    #62.5;
    fmc_noe = 1'b0;
    repeat (20) @(negedge clk);
    check("norb_data_o", 32'(fmc_data_o), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("norb_rst_oe", 32'(fmc_data_oe), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    fmc_noe = 1'b1;
    fmc_ncs = 1'b1;
    repeat (4) @(negedge clk);
    clear_log();
    fmc_write(12'h123, 8'hA5, 1'b0);
    check("post_rst_pulses", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() == 1) begin
      check("post_rst_addr", 32'(wr_addr_log[0]), 32'h123);
      check("post_rst_data", 32'(wr_data_log[0]), 32'hA5);
    end
`ifndef FMC_READBACK_EN
    check("norb_oe_never", 32'(oe_seen), 32'd0);
    check("norb_no_rdreq", 32'(rdq_cnt - rq0), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
